// File: rtl/wb_dmaster_pkg.sv
// Shared definitions for the Wishbone data-bus master: FSM state encodings
// and the default ack-timeout length.
package wb_dmaster_pkg;

    localparam logic [1:0] WBM_IDLE = 2'd0;
    localparam logic [1:0] WBM_BUS  = 2'd1;
    localparam logic [1:0] WBM_TURN = 2'd2;

    localparam int WB_TO_CYCLES = 255;

endpackage

// File: rtl/wb_to_cnt.sv
// Ack-timeout counter for the Wishbone master: cleared when a cycle starts,
// counts BUS cycles without ack, flags expiry at TO_CYCLES-1.
module wb_to_cnt #(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Saturates at the expiry value so a late abort never wraps the count.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TO_CYCLES - 1));

endmodule

// File: rtl/wb_dmaster.sv
// Wishbone data-bus master: turns single-beat CPU load/store requests into
// classic Wishbone cycles. Optional ack timeout enabled by WB_TIMEOUT_EN.
module wb_dmaster
    import wb_dmaster_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int TO_CYCLES = WB_TO_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          ack_i,
    input  logic [DW-1:0] dat_i,
    output logic [1:0]    state_dbg
);

    logic [1:0] state;
    logic       to_expired;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // the CPU holds req_* stable until then. rsp_valid is a one-cycle pulse with no back-pressure.
    assign req_ready = (state == WBM_IDLE);
    assign state_dbg = state;

`ifdef WB_TIMEOUT_EN
    wb_to_cnt #(
        .TO_CYCLES(TO_CYCLES)
    ) u_to_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == WBM_IDLE && req_valid),
        .en     (state == WBM_BUS && !ack_i),
        .expired(to_expired)
    );
`else
    logic [31:0] unused_to_cycles;
    assign unused_to_cycles = TO_CYCLES;
    assign to_expired       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WBM_IDLE;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                WBM_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= req_we;
                        adr_o <= req_adr;
                        dat_o <= req_dat;
                        state <= WBM_BUS;
                    end
                end
                WBM_BUS: begin
                    // Ack takes priority over a coinciding timeout expiry.
                    if (ack_i) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= we_o ? '0 : dat_i;
                        rsp_err   <= 1'b0;
                        state     <= WBM_TURN;
                    end else if (to_expired) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        state     <= WBM_TURN;
                    end
                end
                WBM_TURN: begin
                    // The RAM's registered ack is still high here; it is ignored.
                    rsp_valid <= 1'b0;
                    state     <= WBM_IDLE;
                end
                default: begin
                    state <= WBM_IDLE;
                end
            endcase
        end
    end

endmodule
